// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor with a tagged branch target buffer.
// Fetch lookups produce a registered prediction one cycle later. Resolved branches
// from execute train the shared 2-bit counters and, on a taken outcome, the BTB.
module branch_predictor #(
  parameter int WordSize  = 32,
  parameter int IndexBits = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fetch_valid,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_valid,
  output logic [WordSize-1:0] pred_pc,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_addr,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target
);

  localparam int Entries = 1 << IndexBits;
  localparam int TagBits = WordSize - IndexBits - 2;

  // Counter encoding: the MSB is the predicted direction.
  localparam logic [1:0] CtrStrongNt = 2'b00;
  localparam logic [1:0] CtrWeakNt   = 2'b01;
  localparam logic [1:0] CtrStrongT  = 2'b11;

  logic [1:0]          ctr      [Entries];
  logic                valid_q  [Entries];
  logic [TagBits-1:0]  tag_q    [Entries];
  logic [WordSize-1:0] target_q [Entries];

  logic [IndexBits-1:0] fetch_idx;
  logic [TagBits-1:0]   fetch_tag;
  logic [IndexBits-1:0] upd_idx;
  logic [TagBits-1:0]   upd_tag;

  assign fetch_idx = fetch_pc[IndexBits+1:2];
  assign fetch_tag = fetch_pc[WordSize-1:IndexBits+2];
  assign upd_idx   = upd_pc[IndexBits+1:2];
  assign upd_tag   = upd_pc[WordSize-1:IndexBits+2];

  logic                lookup_hit;
  logic                lookup_taken;
  logic [WordSize-1:0] lookup_addr;

  // Combinational table read; the registered outputs below capture it, so a
  // same-edge update is never seen by this lookup (read-before-write).
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    lookup_hit   = 1'b0;
    lookup_taken = 1'b0;
    lookup_addr  = fetch_pc + WordSize'(4);
    lookup_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    lookup_taken = lookup_hit && ctr[fetch_idx][1];
    if (lookup_taken) begin
      lookup_addr = target_q[fetch_idx];
    end
  end

  // Prediction output register; pc/addr hold across idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
      pred_addr  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pred_valid <= fetch_valid;
      pred_taken <= fetch_valid && lookup_taken;
      if (fetch_valid) begin
        pred_pc   <= fetch_pc;
        pred_addr <= lookup_addr;
      end
    end
  end

  // Table training: untagged saturating counter update, BTB write only on taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the tables are flops, not RAM, precisely so this asynchronous whole-array reset is legal.
      for (int i = 0; i < Entries; i++) begin
        ctr[i]      <= CtrWeakNt;
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (ctr[upd_idx] != CtrStrongT) begin
          ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
        end
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
      end else if (ctr[upd_idx] != CtrStrongNt) begin
        ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (IndexBits = 6).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.WordSize(32), .IndexBits(6)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_addr   (pred_addr),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: inputs change #1 after a rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    fetch_valid = 1'b0;
    upd_valid   = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = target;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b t=%b pc=%h addr=%h, want all zero",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
  endtask

  task automatic test_cold_lookup();
    do_reset();
    lookup(32'h100);
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b1, 1'b0, 32'h100, 32'h104}) begin
      n_fail++;
      $display("FAIL cold_lookup: got v=%b t=%b pc=%h addr=%h, want v=1 t=0 pc=100 addr=104",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
    // Idle cycle: valid/taken drop, pc/addr hold.
    tick();
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b0, 1'b0, 32'h100, 32'h104}) begin
      n_fail++;
      $display("FAIL idle_hold_cold: got v=%b t=%b pc=%h addr=%h, want v=0 t=0 pc=100 addr=104",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
  endtask

  task automatic test_train_taken();
    do_reset();
    train(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    n_tests++;
    if ({pred_valid, pred_taken, pred_addr} !== {1'b1, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL train_taken: got v=%b t=%b addr=%h, want v=1 t=1 addr=200",
               pred_valid, pred_taken, pred_addr);
    end
    tick();
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b0, 1'b0, 32'h100, 32'h200}) begin
      n_fail++;
      $display("FAIL idle_hold_taken: got v=%b t=%b pc=%h addr=%h, want v=0 t=0 pc=100 addr=200",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 32'h200);  // 01->10->11->11
    train(32'h100, 1'b0, 32'h0);                                  // 11->10
    lookup(32'h100);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL hyst_one_nt: got t=%b addr=%h, want t=1 addr=200", pred_taken, pred_addr);
    end
    train(32'h100, 1'b0, 32'h0);                                  // 10->01
    lookup(32'h100);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL hyst_two_nt: got t=%b addr=%h, want t=0 addr=104", pred_taken, pred_addr);
    end
    n_tests++;
    if (dut.valid_q[0] !== 1'b1 || dut.target_q[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL btb_kept_on_nt: got valid=%b target=%h, want valid=1 target=200",
               dut.valid_q[0], dut.target_q[0]);
    end
  endtask

  task automatic test_saturation_floor();
    do_reset();
    train(32'h100, 1'b0, 32'h0);      // 01->00
    train(32'h100, 1'b0, 32'h0);      // stays 00
    train(32'h100, 1'b1, 32'h280);    // 00->01
    lookup(32'h100);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL floor_sat: got t=%b addr=%h, want t=0 addr=104", pred_taken, pred_addr);
    end
    train(32'h100, 1'b1, 32'h280);    // 01->10
    lookup(32'h100);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b1, 32'h280}) begin
      n_fail++;
      $display("FAIL floor_recover: got t=%b addr=%h, want t=1 addr=280", pred_taken, pred_addr);
    end
  endtask

  task automatic test_alias();
    do_reset();
    train(32'h100, 1'b1, 32'h200);
    lookup(32'h200);
    n_tests++;
    if ({pred_taken, pred_pc, pred_addr} !== {1'b0, 32'h200, 32'h204}) begin
      n_fail++;
      $display("FAIL alias_miss: got t=%b pc=%h addr=%h, want t=0 pc=200 addr=204",
               pred_taken, pred_pc, pred_addr);
    end
    train(32'h200, 1'b1, 32'h300);
    lookup(32'h100);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL alias_evict: got t=%b addr=%h, want t=0 addr=104", pred_taken, pred_addr);
    end
    lookup(32'h200);
    n_tests++;
    if ({pred_taken, pred_addr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL alias_owner: got t=%b addr=%h, want t=1 addr=300", pred_taken, pred_addr);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    upd_valid   = 1'b1;
    upd_pc      = 32'h100;
    upd_taken   = 1'b1;
    upd_target  = 32'h240;
    tick();
    upd_valid = 1'b0;
    n_tests++;
    if ({pred_valid, pred_taken, pred_addr} !== {1'b1, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL rbw_same_edge: got v=%b t=%b addr=%h, want v=1 t=0 addr=104",
               pred_valid, pred_taken, pred_addr);
    end
    tick();
    fetch_valid = 1'b0;
    n_tests++;
    if ({pred_valid, pred_taken, pred_addr} !== {1'b1, 1'b1, 32'h240}) begin
      n_fail++;
      $display("FAIL rbw_next_edge: got v=%b t=%b addr=%h, want v=1 t=1 addr=240",
               pred_valid, pred_taken, pred_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    train(32'h100, 1'b1, 32'h200);
    // Lookup index 0 while training index 1 in the same cycle.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    upd_valid   = 1'b1;
    upd_pc      = 32'h104;
    upd_taken   = 1'b1;
    upd_target  = 32'h500;
    tick();
    upd_valid = 1'b0;
    n_tests++;
    if ({pred_taken, pred_pc, pred_addr} !== {1'b1, 32'h100, 32'h200}) begin
      n_fail++;
      $display("FAIL indep_idx0: got t=%b pc=%h addr=%h, want t=1 pc=100 addr=200",
               pred_taken, pred_pc, pred_addr);
    end
    fetch_pc = 32'h104;
    tick();
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b1, 1'b1, 32'h104, 32'h500}) begin
      n_fail++;
      $display("FAIL indep_idx1: got v=%b t=%b pc=%h addr=%h, want v=1 t=1 pc=104 addr=500",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
    fetch_pc = 32'h108;
    tick();
    fetch_valid = 1'b0;
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b1, 1'b0, 32'h108, 32'h10C}) begin
      n_fail++;
      $display("FAIL b2b_cold_idx2: got v=%b t=%b pc=%h addr=%h, want v=1 t=0 pc=108 addr=10c",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    train(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    n_tests++;
    if ({pred_valid, pred_taken, pred_addr} !== {1'b1, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL pre_async_reset: got v=%b t=%b addr=%h, want v=1 t=1 addr=200",
               pred_valid, pred_taken, pred_addr);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_clear: got v=%b t=%b pc=%h addr=%h, want all zero",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
    // A training request presented during reset must be discarded.
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h700;
    tick();
    upd_valid = 1'b0;
    rstn = 1'b1;
    lookup(32'h100);
    n_tests++;
    if ({pred_valid, pred_taken, pred_addr} !== {1'b1, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL post_reset_cold: got v=%b t=%b addr=%h, want v=1 t=0 addr=104",
               pred_valid, pred_taken, pred_addr);
    end
  endtask

  task automatic test_wrap();
    lookup(32'hFFFF_FFFC);
    n_tests++;
    if ({pred_valid, pred_taken, pred_pc, pred_addr} !== {1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap: got v=%b t=%b pc=%h addr=%h, want v=1 t=0 pc=fffffffc addr=0",
               pred_valid, pred_taken, pred_pc, pred_addr);
    end
  endtask

  initial begin
    test_reset();
    test_cold_lookup();
    test_train_taken();
    test_hysteresis();
    test_saturation_floor();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
